// File: rtl/exec_step_controller_if.sv
// Run-control bundle between the board switches/CPU/divider and exec_step_controller.
// The master side drives switches, button, HLT and tick; the slave side is the controller.
interface exec_step_controller_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start_sw;
    logic                 step_mode_sw;
    logic                 btn_step;
    logic                 halt_instr;
    logic                 tick;
    logic                 congela;
    logic                 halt;
    logic                 led_run;
    logic                 led_halted;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        output start_sw, step_mode_sw, btn_step, halt_instr, tick,
        input  congela, halt, led_run, led_halted, state, instr_count
    );

    modport slave (
        input  start_sw, step_mode_sw, btn_step, halt_instr, tick,
        output congela, halt, led_run, led_halted, state, instr_count
    );
endinterface

// File: rtl/exec_step_controller.sv
// Run-control sequencer for the CPU clock divider: free run, single step per debounced
// button press, stop on HLT, or freeze; counts executed divider ticks for the display.
module exec_step_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_WIDTH        = 20,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                  clock_fpga,
    input  logic                  reset,
    exec_step_controller_if.slave bus
);

    typedef enum logic [2:0] {
        FROZEN     = 3'd0,
        RUN        = 3'd1,
        STEP_IDLE  = 3'd2,
        STEP_ARMED = 3'd3,
        HALTED     = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic                 btn_meta_reg, btn_sync_reg;
    logic [DB_WIDTH-1:0]  db_cnt_reg;
    logic                 db_level_reg, db_level_d_reg;
    logic                 step_pulse;
    logic                 congela_reg, halt_reg, led_run_reg, led_halted_reg;
    logic [CNT_WIDTH-1:0] count_reg;

    // The debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            btn_meta_reg   <= 1'b0;
            btn_sync_reg   <= 1'b0;
            db_cnt_reg     <= '0;
            db_level_reg   <= 1'b0;
            db_level_d_reg <= 1'b0;
        end else begin
            btn_meta_reg   <= bus.btn_step;
            btn_sync_reg   <= btn_meta_reg;
            db_level_d_reg <= db_level_reg;
            if (btn_sync_reg == db_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_WIDTH'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt_reg   <= '0;
                db_level_reg <= btn_sync_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    assign step_pulse = db_level_reg & ~db_level_d_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FROZEN: begin
                if (bus.start_sw)
                    state_next = bus.step_mode_sw ? STEP_IDLE : RUN;
            end
            RUN: begin
                if (!bus.start_sw)         state_next = FROZEN;
                else if (bus.halt_instr)   state_next = HALTED;
                else if (bus.step_mode_sw) state_next = STEP_IDLE;
            end
            STEP_IDLE: begin
                if (!bus.start_sw)          state_next = FROZEN;
                else if (bus.halt_instr)    state_next = HALTED;
                else if (!bus.step_mode_sw) state_next = RUN;
                else if (step_pulse)        state_next = STEP_ARMED;
            end
            STEP_ARMED: begin
                // Further presses while armed are dropped; exactly one tick is released.
                if (!bus.start_sw) state_next = FROZEN;
                else if (bus.tick) state_next = bus.halt_instr ? HALTED : STEP_IDLE;
            end
            HALTED: begin
                if (!bus.start_sw) state_next = FROZEN;
            end
            default: state_next = FROZEN;
        endcase
    end

    always_ff @(posedge clock_fpga) begin
        if (reset) begin
            state_reg      <= FROZEN;
            congela_reg    <= 1'b1;
            halt_reg       <= 1'b0;
            led_run_reg    <= 1'b0;
            led_halted_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            congela_reg    <= (state_next == FROZEN);
            halt_reg       <= (state_next == STEP_IDLE) || (state_next == HALTED);
            led_run_reg    <= (state_next == RUN) || (state_next == STEP_ARMED);
            led_halted_reg <= (state_next == HALTED);
        end
    end

    // Count follows the current state, so a tick on the cycle that leaves RUN still counts.
    always_ff @(posedge clock_fpga) begin
        if (reset || state_reg == FROZEN) begin
            count_reg <= '0;
        end else if (bus.tick && (state_reg == RUN || state_reg == STEP_ARMED)
                     && count_reg != {CNT_WIDTH{1'b1}}) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign bus.congela     = congela_reg;
    assign bus.halt        = halt_reg;
    assign bus.led_run     = led_run_reg;
    assign bus.led_halted  = led_halted_reg;
    assign bus.state       = state_reg;
    assign bus.instr_count = count_reg;

endmodule
